branch_target_buffer: RTL and testbench



---
 rtl/rv32i_types.sv | 23 ++
 rtl/btb_way.sv | 58 +++++
 rtl/branch_target_buffer.sv | 157 +++++++++++++++
 tb/tb_branch_target_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: BTB entry layout, BTB sizing and sweep FSM states.
package rv32i_types;

  localparam int unsigned btb_s_index        = 4;
  localparam int unsigned perf_counter_width = 32;

  typedef enum logic [1:0] {
    br   = 2'b00,
    jal  = 2'b01,
    jalr = 2'b10
  } btb_ops;

  typedef struct packed {
    logic [31:0] target_address;
    btb_ops      br_jal_jalr;
  } btb_entry;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } btb_state_t;

endpackage

// File: rtl/btb_way.sv
// One BTB way: per-set valid/tag/entry storage, combinational lookups,
// synchronous write and a single-set clear used by the invalidation sweep.
module btb_way
  import rv32i_types::*;
#(
  parameter int unsigned S_INDEX = btb_s_index,
  parameter int unsigned TAG_W   = 30 - btb_s_index
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rd_match,
  output logic [33:0]        rd_data,
  input  logic [S_INDEX-1:0] upd_index,
  input  logic [TAG_W-1:0]   upd_tag,
  output logic               upd_match,
  output logic               upd_vld,
  input  logic               wr_en,
  input  logic [33:0]        wr_data,
  input  logic               clr_en,
  input  logic [S_INDEX-1:0] clr_index
);

  localparam int unsigned SETS = 2 ** S_INDEX;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [33:0]      data [SETS];

  // Lookup ports for the fetch read and for the update's victim selection
  always_comb begin
    rd_match  = valid[rd_index] && (tags[rd_index] == rd_tag);
    rd_data   = data[rd_index];
    upd_vld   = valid[upd_index];
    upd_match = valid[upd_index] && (tags[upd_index] == upd_tag);
  end

  // Valid bits: reset and sweep clear take priority over an install
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (clr_en) begin
      valid[clr_index] <= 1'b0;
    end else if (wr_en) begin
      valid[upd_index] <= 1'b1;
    end
  end

  // Tag and entry storage; no reset needed since valid gates every use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[upd_index] <= upd_tag;
      data[upd_index] <= wr_data;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer with per-set LRU and a
// flush-triggered invalidation sweep. Optional perf counters are built when
// BTB_PERF_CNT_EN is defined.
module branch_target_buffer
  import rv32i_types::*;
#(
  parameter int unsigned S_INDEX = btb_s_index,
  parameter int unsigned TAG_W   = 30 - S_INDEX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  input  logic        rd_valid,
  output logic        rd_hit,
  output logic [33:0] rd_entry,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_type,
  input  logic        flush,
  output logic        busy
`ifdef BTB_PERF_CNT_EN
  ,
  output logic [perf_counter_width-1:0] lookup_count,
  output logic [perf_counter_width-1:0] hit_count
`endif
);

  localparam int unsigned SETS = 2 ** S_INDEX;

  btb_state_t         state, state_next;
  logic [S_INDEX-1:0] cnt, cnt_next;
  logic [SETS-1:0]    lru;

  logic [S_INDEX-1:0] rd_index, upd_index;
  logic [TAG_W-1:0]   rd_tag, upd_tag;
  logic               hit0, hit1, m0, m1, v0, v1;
  logic [33:0]        data0, data1;
  logic               hit_way, wr_way, upd_en;
  logic [33:0]        wr_data;
  logic               unused_pc_bits;

  assign rd_index       = rd_pc[S_INDEX+1:2];
  assign rd_tag         = rd_pc[31:S_INDEX+2];
  assign upd_index      = upd_pc[S_INDEX+1:2];
  assign upd_tag        = upd_pc[31:S_INDEX+2];
  assign unused_pc_bits = ^{rd_pc[1:0], upd_pc[1:0]};
  assign wr_data        = {upd_target, upd_type};
  assign busy           = (state == SWEEP);
  assign upd_en         = upd_valid && !busy;

  btb_way #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst(rst),
    .rd_index(rd_index), .rd_tag(rd_tag), .rd_match(hit0), .rd_data(data0),
    .upd_index(upd_index), .upd_tag(upd_tag), .upd_match(m0), .upd_vld(v0),
    .wr_en(upd_en && !wr_way), .wr_data(wr_data),
    .clr_en(busy), .clr_index(cnt)
  );

  btb_way #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst(rst),
    .rd_index(rd_index), .rd_tag(rd_tag), .rd_match(hit1), .rd_data(data1),
    .upd_index(upd_index), .upd_tag(upd_tag), .upd_match(m1), .upd_vld(v1),
    .wr_en(upd_en && wr_way), .wr_data(wr_data),
    .clr_en(busy), .clr_index(cnt)
  );

  // Read mux: way 0 wins if both ways ever match; lookups are blocked while sweeping
  always_comb begin
    rd_hit   = !busy && (hit0 || hit1);
    hit_way  = !hit0;
    rd_entry = '0;
    if (rd_hit) begin
      rd_entry = hit0 ? data0 : data1;
    end
  end

  // Update way: existing tag, else lowest invalid way, else LRU victim
  always_comb begin
    wr_way = lru[upd_index];
    if (m0) begin
      wr_way = 1'b0;
    end else if (m1) begin
      wr_way = 1'b1;
    end else if (!v0) begin
      wr_way = 1'b0;
    end else if (!v1) begin
      wr_way = 1'b1;
    end
  end

  // LRU: read touch first so an update to the same set overrides it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru <= '0;
    end else if (busy) begin
      lru[cnt] <= 1'b0;
    end else begin
      if (rd_valid && rd_hit) begin
        lru[rd_index] <= ~hit_way;
      end
      if (upd_en) begin
        lru[upd_index] <= ~wr_way;
      end
    end
  end

  // Sweep FSM state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Sweep FSM next state: one set cleared per cycle, flush ignored mid-sweep
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (flush) begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        cnt_next = cnt + S_INDEX'(1);
        if (cnt == '1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BTB_PERF_CNT_EN
  // Saturating lookup and hit counters; untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_count <= '0;
      hit_count    <= '0;
    end else if (rd_valid) begin
      if (lookup_count != '1) begin
        lookup_count <= lookup_count + perf_counter_width'(1);
      end
      if (rd_hit && (hit_count != '1)) begin
        hit_count <= hit_count + perf_counter_width'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: expectations are queued as
// stimulus is driven and checked at the following falling edge.
module tb_branch_target_buffer;
  import rv32i_types::*;

  logic        clk, rst;
  logic [31:0] rd_pc, upd_pc, upd_target;
  logic        rd_valid, upd_valid, flush;
  logic [1:0]  upd_type;
  logic        rd_hit, busy;
  logic [33:0] rd_entry;
`ifdef BTB_PERF_CNT_EN
  logic [perf_counter_width-1:0] lookup_count, hit_count;
`endif

  branch_target_buffer dut (
    .clk(clk), .rst(rst),
    .rd_pc(rd_pc), .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_entry(rd_entry),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_type(upd_type), .flush(flush), .busy(busy)
`ifdef BTB_PERF_CNT_EN
    , .lookup_count(lookup_count), .hit_count(hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  localparam logic [1:0] T_BR   = 2'(br);
  localparam logic [1:0] T_JAL  = 2'(jal);
  localparam logic [1:0] T_JALR = 2'(jalr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_rd(input string tag, input logic hit, input logic [31:0] tgt, input logic [1:0] typ);
    sb_t e;
    e.tag  = tag;
    e.kind = 0;
    e.exp  = hit ? 64'({1'b1, tgt, typ}) : 64'd0;
    sb.push_back(e);
  endtask

  task automatic exp_busy(input string tag, input logic b);
    sb_t e;
    e.tag  = tag;
    e.kind = 1;
    e.exp  = 64'(b);
    sb.push_back(e);
  endtask

`ifdef BTB_PERF_CNT_EN
  task automatic exp_perf(input string tag, input int kind, input int unsigned v);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = 64'(v);
    sb.push_back(e);
  endtask
`endif

  // One cycle: drain the scoreboard at the falling edge, then idle inputs after the rising edge
  task automatic step();
    sb_t         e;
    logic [63:0] got;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = '0;
      case (e.kind)
        0: got = 64'({rd_hit, rd_entry});
        1: got = 64'(busy);
`ifdef BTB_PERF_CNT_EN
        2: got = 64'(lookup_count);
        3: got = 64'(hit_count);
`endif
        default: got = '1;
      endcase
      check(e.tag, got, e.exp);
    end
    @(posedge clk);
    #1;
    rd_valid  = 1'b0;
    upd_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] pc, input logic v);
    rd_pc    = pc;
    rd_valid = v;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_type   = typ;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Watchdog so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rd_pc = 32'h40; rd_valid = 1'b0; upd_valid = 1'b0;
    upd_pc = '0; upd_target = '0; upd_type = '0; flush = 1'b0;
    @(posedge clk);
    #1;
    exp_rd("reset_rd", 1'b0, 32'h0, 2'b00);
    exp_busy("reset_busy", 1'b0);
    step();
    rst = 1'b0;

    // Basic install and lookup
    rd(32'h40, 1'b0); exp_rd("cold_lookup", 1'b0, 32'h0, 2'b00); step();
    upd(32'h40, 32'h100, T_JAL); step();
    rd(32'h40, 1'b0); exp_rd("hit_40", 1'b1, 32'h100, T_JAL); step();
    rd(32'h440, 1'b0); exp_rd("miss_440", 1'b0, 32'h0, 2'b00); step();

    // Same-cycle read and update: old contents visible, then updated in place
    rd(32'h40, 1'b0); upd(32'h40, 32'h200, T_JAL);
    exp_rd("rd_upd_old", 1'b1, 32'h100, T_JAL); step();
    rd(32'h40, 1'b0); exp_rd("rd_upd_new", 1'b1, 32'h200, T_JAL); step();
    upd(32'h440, 32'h300, T_BR); step();
    rd(32'h40, 1'b0); exp_rd("nodup_40", 1'b1, 32'h200, T_JAL); step();
    rd(32'h440, 1'b0); exp_rd("nodup_440", 1'b1, 32'h300, T_BR); step();

    // Conflict and LRU replacement in set 0
    do_reset();
    upd(32'h000, 32'h1000, T_BR); step();
    upd(32'h400, 32'h2000, T_JALR); step();
    rd(32'h000, 1'b1); exp_rd("touch_000", 1'b1, 32'h1000, T_BR); step();
    upd(32'h800, 32'h3000, T_JAL); step();
    rd(32'h000, 1'b0); exp_rd("keep_000", 1'b1, 32'h1000, T_BR); step();
    rd(32'h800, 1'b0); exp_rd("new_800", 1'b1, 32'h3000, T_JAL); step();
    rd(32'h400, 1'b0); exp_rd("evict_400", 1'b0, 32'h0, 2'b00); step();

    // Flush sweep with dropped update, forced miss and ignored re-flush
    upd(32'h3C, 32'h4000, T_JALR); step();
    upd(32'h44, 32'h5000, T_BR); step();
    rd(32'h3C, 1'b0); exp_rd("pre_flush_3c", 1'b1, 32'h4000, T_JALR); step();
    flush = 1'b1; upd(32'h48, 32'h6000, T_JAL);
    exp_busy("flush_cycle_busy", 1'b0); step();
    for (int k = 0; k < 16; k++) begin
      if (k == 2) begin
        rd(32'h3C, 1'b0); exp_rd("sweep_forced_miss", 1'b0, 32'h0, 2'b00);
      end
      if (k == 5) upd(32'hC00, 32'h7000, T_BR);
      if (k == 8) flush = 1'b1;
      exp_busy($sformatf("sweep_busy_%0d", k), 1'b1);
      step();
    end
    exp_busy("sweep_done", 1'b0); step();
    rd(32'h000, 1'b0); exp_rd("post_flush_000", 1'b0, 32'h0, 2'b00); step();
    rd(32'h800, 1'b0); exp_rd("post_flush_800", 1'b0, 32'h0, 2'b00); step();
    rd(32'h3C,  1'b0); exp_rd("post_flush_3c",  1'b0, 32'h0, 2'b00); step();
    rd(32'h44,  1'b0); exp_rd("post_flush_44",  1'b0, 32'h0, 2'b00); step();
    rd(32'h48,  1'b0); exp_rd("post_flush_48",  1'b0, 32'h0, 2'b00); step();
    rd(32'hC00, 1'b0); exp_rd("dropped_upd_c00", 1'b0, 32'h0, 2'b00); step();

    // Reset in the middle of a sweep
    upd(32'h3C, 32'h8000, T_JAL); step();
    upd(32'h38, 32'h9000, T_BR); step();
    rd(32'h38, 1'b0); exp_rd("pre_rst_38", 1'b1, 32'h9000, T_BR); step();
    flush = 1'b1; step();
    for (int k = 0; k < 5; k++) begin
      exp_busy($sformatf("rst_sweep_busy_%0d", k), 1'b1);
      step();
    end
    rst = 1'b1;
    exp_busy("rst_mid_sweep_busy", 1'b0);
    step();
    rst = 1'b0;
    rd(32'h3C, 1'b0); exp_rd("rst_mid_3c", 1'b0, 32'h0, 2'b00); step();
    rd(32'h38, 1'b0); exp_rd("rst_mid_38", 1'b0, 32'h0, 2'b00); exp_busy("rst_mid_idle", 1'b0); step();

`ifdef BTB_PERF_CNT_EN
    // Performance counters: 10 lookups, 4 hits
    do_reset();
    upd(32'h40, 32'h100, T_JAL); step();
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        rd(32'h40, 1'b1); exp_rd($sformatf("perf_hit_%0d", i), 1'b1, 32'h100, T_JAL);
      end else begin
        rd(32'h80, 1'b1); exp_rd($sformatf("perf_miss_%0d", i), 1'b0, 32'h0, 2'b00);
      end
      step();
    end
    exp_perf("lookup_count", 2, 10);
    exp_perf("hit_count", 3, 4);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
